id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, register width; NUM_REGS, default 16, register count (power of 2, REG_AW = log2); ADDR_W, default 32, PC width; FORWARD_EN, default 0, 1 = EXE forwarding present so only load-use stalls.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 pc_in  in  ADDR_W; instr_in  in  32; valid_in  in  1: IF/ID stage contents.
REQ-005 wb_en  in  1; wb_addr  in  REG_AW; wb_data  in  DATA_W: write-back port.
REQ-006 status_in  in  4  live NZCV from status register.
REQ-007 ex_dest, mem_dest  in  REG_AW; ex_wb_en, mem_wb_en, ex_mem_read  in  1: downstream destinations for hazard check.
REQ-008 flush  in  1  branch taken in EXE.
REQ-009 stall  out  1  combinational; freezes PC and IF/ID.
REQ-010 Registered outputs: valid_out 1; pc_out ADDR_W; exec_cmd EXECUTE_COMMAND_LEN; mem_read, mem_write, wb_en_out, imm, branch, s_en 1 each; val_rn, val_rm DATA_W; shift_operand 12; signed_imm 24; dest, src1_out, src2_out REG_AW.

Function
REQ-011 Decode SHALL use the existing ControlUnit encoding from instr[27:26], [24:21], [20], [25].
REQ-012 src1 = instr[19:16]; src2 = instr[15:12] if mem_write else instr[3:0]; two_src = ~instr[25] | mem_write.
REQ-013 uses_src1 SHALL be 0 for mode 2'b10 (branch) and for mode 00 opcodes MOV 4'b1101, MVN 4'b1111; else 1.
REQ-014 FORWARD_EN=0: hazard = valid_in & ((uses_src1 & match(src1)) | (two_src & match(src2))), match(r) = (ex_wb_en & r==ex_dest) | (mem_wb_en & r==mem_dest).
REQ-015 FORWARD_EN=1: hazard = valid_in & ex_mem_read & ((uses_src1 & src1==ex_dest) | (two_src & src2==ex_dest)).
REQ-016 stall = hazard & ~flush.
REQ-017 Condition: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE on status_in; 4'b1110 always; 4'b1111 never.
REQ-018 Register file: write on rising edge when wb_en; reads combinational with bypass: read addr == wb_addr & wb_en returns wb_data same cycle.
REQ-019 ID/EX load priority per edge: flush > stall > condition fail > normal.
REQ-020 flush or stall: valid_out=0, all control outputs 0; data fields don't-care but SHALL be zeroed.
REQ-021 Condition fail (valid_in=1): valid_out=0, control outputs 0, pc_out/dest loaded.
REQ-022 Normal: all outputs loaded from decode; valid_out=valid_in; valid_in=0 forces control outputs 0.
REQ-023 Latency: instruction presented in cycle N appears on outputs after edge N+1 unless stalled; a stalled instruction is re-decoded next cycle from held IF/ID.
REQ-024 Simultaneous wb and hazard: hazard evaluated from ex/mem ports only; wb bypass does not clear it.

Reset
REQ-025 rst low SHALL asynchronously clear all ID/EX outputs and all registers to 0; stall is combinational and SHALL be 0 while valid_in=0.
REQ-026 Reset mid-stall SHALL discard the pending bubble; first post-reset edge loads normally.

Structure
REQ-027 Shared package/Defines: EXECUTE_COMMAND_LEN, mode/opcode constants, condition codes, SHIFT_OPERAND_LEN, SIGNED_IMMEDIATE_LEN.
REQ-028 One sub-module: reg_file_bypass (NUM_REGS x DATA_W, 2 read, 1 write, bypass); ControlUnit instantiated unchanged.

Verification
REQ-029 ADD R1,R2,R3 (cond AL), R2=5,R3=7 preloaded -> next edge: valid_out=1, val_rn=5, val_rm=7, wb_en_out=1, dest=1.
REQ-030 FORWARD_EN=0, ex_wb_en=1, ex_dest=2, instr reads R2 -> stall=1, next edge valid_out=0, controls 0; clear ex_wb_en -> instruction issues.
REQ-031 FORWARD_EN=1 same case, ex_mem_read=0 -> stall=0; ex_mem_read=1 -> stall=1.
REQ-032 wb_en=1, wb_addr=4, wb_data=0xDEAD, instr reads R4 same cycle -> val_rn=0xDEAD.
REQ-033 EQ instr with status_in=4'b0000 -> valid_out=0, wb_en_out=0; status_in=4'b0100 -> executes.
REQ-034 flush=1 with hazard=1 -> stall=0, bubble loaded; rst low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants, control bundle and condition evaluation for the ID stage.
package id_stage_pipe_pkg;

  localparam int unsigned EXECUTE_COMMAND_LEN  = 4;
  localparam int unsigned SHIFT_OPERAND_LEN    = 12;
  localparam int unsigned SIGNED_IMMEDIATE_LEN = 24;

  // instr[27:26]
  localparam logic [1:0] ModeArith  = 2'b00;
  localparam logic [1:0] ModeMem    = 2'b01;
  localparam logic [1:0] ModeBranch = 2'b10;

  // instr[24:21] in arithmetic mode
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpMvn = 4'b1111;

  // ALU commands handed to EXE
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ExeNop = 4'b0000;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ExeMov = 4'b0001;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ExeAdd = 4'b0010;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ExeAdc = 4'b0011;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ExeSub = 4'b0100;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ExeSbc = 4'b0101;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ExeAnd = 4'b0110;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ExeOrr = 4'b0111;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ExeEor = 4'b1000;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ExeMvn = 4'b1001;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;

  typedef struct packed {
    logic [EXECUTE_COMMAND_LEN-1:0] exec_cmd;
    logic                           mem_read;
    logic                           mem_write;
    logic                           wb_en;
    logic                           imm;
    logic                           branch;
    logic                           s_en;
  } ctrl_t;

  // nzcv = {N, Z, C, V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    {n, z, c, v} = nzcv;
    case (cond)
      CondEq:  res = z;
      CondNe:  res = ~z;
      CondCs:  res = c;
      CondCc:  res = ~c;
      CondMi:  res = n;
      CondPl:  res = ~n;
      CondVs:  res = v;
      CondVc:  res = ~v;
      CondHi:  res = c & ~z;
      CondLs:  res = ~c | z;
      CondGe:  res = (n == v);
      CondLt:  res = (n != v);
      CondGt:  res = ~z & (n == v);
      CondLe:  res = z | (n != v);
      CondAl:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Instruction class decoder: mode/opcode/S/I bits to the EXE control bundle.
module control_unit
  import id_stage_pipe_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic [3:0] opcode_i,
  input  logic       s_i,
  input  logic       imm_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o     = '0;
    ctrl_o.imm = imm_i;
    unique case (mode_i)
      ModeArith: begin
        ctrl_o.s_en = s_i;
        unique case (opcode_i)
          OpMov:   begin ctrl_o.exec_cmd = ExeMov; ctrl_o.wb_en = 1'b1; end
          OpMvn:   begin ctrl_o.exec_cmd = ExeMvn; ctrl_o.wb_en = 1'b1; end
          OpAdd:   begin ctrl_o.exec_cmd = ExeAdd; ctrl_o.wb_en = 1'b1; end
          OpAdc:   begin ctrl_o.exec_cmd = ExeAdc; ctrl_o.wb_en = 1'b1; end
          OpSub:   begin ctrl_o.exec_cmd = ExeSub; ctrl_o.wb_en = 1'b1; end
          OpSbc:   begin ctrl_o.exec_cmd = ExeSbc; ctrl_o.wb_en = 1'b1; end
          OpAnd:   begin ctrl_o.exec_cmd = ExeAnd; ctrl_o.wb_en = 1'b1; end
          OpOrr:   begin ctrl_o.exec_cmd = ExeOrr; ctrl_o.wb_en = 1'b1; end
          OpEor:   begin ctrl_o.exec_cmd = ExeEor; ctrl_o.wb_en = 1'b1; end
          OpCmp:   ctrl_o.exec_cmd = ExeSub;
          OpTst:   ctrl_o.exec_cmd = ExeAnd;
          default: ctrl_o.exec_cmd = ExeNop;
        endcase
      end
      // S selects LDR (1) versus STR (0); both compute the address by addition
      ModeMem: begin
        ctrl_o.exec_cmd  = ExeAdd;
        ctrl_o.mem_read  = s_i;
        ctrl_o.wb_en     = s_i;
        ctrl_o.mem_write = ~s_i;
      end
      ModeBranch: ctrl_o.branch = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_file_bypass.sv
// Register file with two combinational read ports, one write port and write-to-read bypass.
module reg_file_bypass #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (we_i && (raddr_a_i == waddr_i)) ? wdata_i : regs_q[raddr_a_i];
  assign rdata_b_o = (we_i && (raddr_b_i == waddr_i)) ? wdata_i : regs_q[raddr_b_i];

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register read, hazard detection, condition check and the ID/EX register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter bit          FORWARD_EN = 1'b0,
  localparam int unsigned REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_W-1:0]               pc_in,
  input  logic [31:0]                     instr_in,
  input  logic                            valid_in,
  input  logic                            wb_en,
  input  logic [REG_AW-1:0]               wb_addr,
  input  logic [DATA_W-1:0]               wb_data,
  input  logic [3:0]                      status_in,
  input  logic [REG_AW-1:0]               ex_dest,
  input  logic [REG_AW-1:0]               mem_dest,
  input  logic                            ex_wb_en,
  input  logic                            mem_wb_en,
  input  logic                            ex_mem_read,
  input  logic                            flush,
  output logic                            stall,
  output logic                            valid_out,
  output logic [ADDR_W-1:0]               pc_out,
  output logic [EXECUTE_COMMAND_LEN-1:0]  exec_cmd,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic                            wb_en_out,
  output logic                            imm,
  output logic                            branch,
  output logic                            s_en,
  output logic [DATA_W-1:0]               val_rn,
  output logic [DATA_W-1:0]               val_rm,
  output logic [SHIFT_OPERAND_LEN-1:0]    shift_operand,
  output logic [SIGNED_IMMEDIATE_LEN-1:0] signed_imm,
  output logic [REG_AW-1:0]               dest,
  output logic [REG_AW-1:0]               src1_out,
  output logic [REG_AW-1:0]               src2_out
);

  ctrl_t             ctrl;
  logic [REG_AW-1:0] src1, src2, rd;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              two_src, uses_src1, hazard, cond_ok;

  control_unit u_control_unit (
    .mode_i  (instr_in[27:26]),
    .opcode_i(instr_in[24:21]),
    .s_i     (instr_in[20]),
    .imm_i   (instr_in[25]),
    .ctrl_o  (ctrl)
  );

  assign src1    = instr_in[16 +: REG_AW];
  assign rd      = instr_in[12 +: REG_AW];
  assign src2    = ctrl.mem_write ? rd : instr_in[0 +: REG_AW];
  assign two_src = ~instr_in[25] | ctrl.mem_write;
  assign cond_ok = cond_pass(instr_in[31:28], status_in);

  // Branches and MOV/MVN never read Rn
  assign uses_src1 = ~((instr_in[27:26] == ModeBranch) ||
                       ((instr_in[27:26] == ModeArith) &&
                        ((instr_in[24:21] == OpMov) || (instr_in[24:21] == OpMvn))));

  reg_file_bypass #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_reg_file (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr_a_i(src1),
    .rdata_a_o(rdata_a),
    .raddr_b_i(src2),
    .rdata_b_o(rdata_b)
  );

  // The write-back bypass does not clear a hazard: only the ex/mem ports are consulted
  always_comb begin
    if (FORWARD_EN) begin
      hazard = valid_in & ex_mem_read &
               ((uses_src1 & (src1 == ex_dest)) | (two_src & (src2 == ex_dest)));
    end else begin
      hazard = valid_in &
               ((uses_src1 & ((ex_wb_en & (src1 == ex_dest)) | (mem_wb_en & (src1 == mem_dest)))) |
                (two_src   & ((ex_wb_en & (src2 == ex_dest)) | (mem_wb_en & (src2 == mem_dest)))));
    end
  end

  assign stall = hazard & ~flush;

  logic                            valid_d, valid_q;
  logic [ADDR_W-1:0]               pc_d, pc_q;
  ctrl_t                           ctrl_d, ctrl_q;
  logic [DATA_W-1:0]               val_rn_d, val_rn_q, val_rm_d, val_rm_q;
  logic [SHIFT_OPERAND_LEN-1:0]    shift_d, shift_q;
  logic [SIGNED_IMMEDIATE_LEN-1:0] simm_d, simm_q;
  logic [REG_AW-1:0]               dest_d, dest_q, src1_d, src1_q, src2_d, src2_q;

  always_comb begin
    valid_d  = 1'b0;
    pc_d     = '0;
    ctrl_d   = '0;
    val_rn_d = '0;
    val_rm_d = '0;
    shift_d  = '0;
    simm_d   = '0;
    dest_d   = '0;
    src1_d   = '0;
    src2_d   = '0;
    if (flush || stall) begin
      // bubble: everything stays zero
    end else if (valid_in && !cond_ok) begin
      pc_d   = pc_in;
      dest_d = rd;
    end else begin
      valid_d  = valid_in;
      pc_d     = pc_in;
      ctrl_d   = valid_in ? ctrl : '0;
      val_rn_d = rdata_a;
      val_rm_d = rdata_b;
      shift_d  = instr_in[SHIFT_OPERAND_LEN-1:0];
      simm_d   = instr_in[SIGNED_IMMEDIATE_LEN-1:0];
      dest_d   = rd;
      src1_d   = src1;
      src2_d   = src2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      ctrl_q   <= '0;
      val_rn_q <= '0;
      val_rm_q <= '0;
      shift_q  <= '0;
      simm_q   <= '0;
      dest_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      ctrl_q   <= ctrl_d;
      val_rn_q <= val_rn_d;
      val_rm_q <= val_rm_d;
      shift_q  <= shift_d;
      simm_q   <= simm_d;
      dest_q   <= dest_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
    end
  end

  assign valid_out     = valid_q;
  assign pc_out        = pc_q;
  assign exec_cmd      = ctrl_q.exec_cmd;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign wb_en_out     = ctrl_q.wb_en;
  assign imm           = ctrl_q.imm;
  assign branch        = ctrl_q.branch;
  assign s_en          = ctrl_q.s_en;
  assign val_rn        = val_rn_q;
  assign val_rm        = val_rm_q;
  assign shift_operand = shift_q;
  assign signed_imm    = simm_q;
  assign dest          = dest_q;
  assign src1_out      = src1_q;
  assign src2_out      = src2_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Random and directed checks of id_stage_pipe (both FORWARD_EN settings) against an ISA-level model.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in, instr_in, wb_data;
  logic        valid_in, wb_en, ex_wb_en, mem_wb_en, ex_mem_read, flush;
  logic [3:0]  wb_addr, status_in, ex_dest, mem_dest;

  logic        stall_o [2], valid_o [2], mr_o [2], mw_o [2], wbe_o [2], imm_o [2], br_o [2];
  logic        s_o [2];
  logic [31:0] pc_o [2], rn_o [2], rm_o [2];
  logic [3:0]  exec_o [2], dest_o [2], s1_o [2], s2_o [2];
  logic [11:0] sh_o [2];
  logic [23:0] si_o [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_rf [16];
  logic [3:0]  exe_tab [16];
  bit          wr_tab [16];

  typedef struct {
    logic         stall;
    logic         valid;
    logic [31:0]  pc;
    logic [9:0]   ctrl;
    logic [3:0]   dest;
    logic [107:0] data;
    bit           data_chk;
  } exp_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_stage_pipe #(
      .DATA_W    (32),
      .NUM_REGS  (16),
      .ADDR_W    (32),
      .FORWARD_EN(g == 1)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_in        (pc_in),
      .instr_in     (instr_in),
      .valid_in     (valid_in),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .status_in    (status_in),
      .ex_dest      (ex_dest),
      .mem_dest     (mem_dest),
      .ex_wb_en     (ex_wb_en),
      .mem_wb_en    (mem_wb_en),
      .ex_mem_read  (ex_mem_read),
      .flush        (flush),
      .stall        (stall_o[g]),
      .valid_out    (valid_o[g]),
      .pc_out       (pc_o[g]),
      .exec_cmd     (exec_o[g]),
      .mem_read     (mr_o[g]),
      .mem_write    (mw_o[g]),
      .wb_en_out    (wbe_o[g]),
      .imm          (imm_o[g]),
      .branch       (br_o[g]),
      .s_en         (s_o[g]),
      .val_rn       (rn_o[g]),
      .val_rm       (rm_o[g]),
      .shift_operand(sh_o[g]),
      .signed_imm   (si_o[g]),
      .dest         (dest_o[g]),
      .src1_out     (s1_o[g]),
      .src2_out     (s2_o[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // NZCV condition rule: pairs of codes are a test and its inverse
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], z = f[2], cf = f[1], v = f[0];
    bit r;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    return c[0] ? !r : r;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [3:0] r);
    return (wb_en && wb_addr == r) ? wb_data : model_rf[r];
  endfunction

  function automatic bit busy(input logic [3:0] r);
    return (ex_wb_en && r == ex_dest) || (mem_wb_en && r == mem_dest);
  endfunction

  function automatic exp_t model(input bit fwd);
    exp_t e;
    logic [1:0] mode = instr_in[27:26];
    logic [3:0] op = instr_in[24:21];
    bit ldr = (mode == 2'b01) && instr_in[20];
    bit str = (mode == 2'b01) && !instr_in[20];
    logic [3:0] r1 = instr_in[19:16];
    logic [3:0] r2 = str ? instr_in[15:12] : instr_in[3:0];
    bit reads1 = !(mode == 2'b10 || (mode == 2'b00 && (op == 4'hD || op == 4'hF)));
    bit reads2 = !instr_in[25] || str;
    bit hz;
    logic [3:0] exe = 4'h0;
    bit wr = 0;
    if (fwd) hz = ex_mem_read && ((reads1 && r1 == ex_dest) || (reads2 && r2 == ex_dest));
    else     hz = (reads1 && busy(r1)) || (reads2 && busy(r2));
    hz = hz && valid_in;
    if (mode == 2'b00) begin exe = exe_tab[op]; wr = wr_tab[op]; end
    if (mode == 2'b01) begin exe = 4'h2; wr = ldr; end
    e.stall = hz && !flush;
    e.valid = 1'b0;
    e.pc = '0;
    e.ctrl = '0;
    e.dest = '0;
    e.data = '0;
    e.data_chk = 1'b1;
    if (flush || e.stall) begin
    end else if (valid_in && !cond_holds(instr_in[31:28], status_in)) begin
      e.pc = pc_in;
      e.dest = instr_in[15:12];
      e.data_chk = 1'b0;
    end else begin
      e.valid = valid_in;
      e.pc = pc_in;
      if (valid_in)
        e.ctrl = {exe, ldr, str, wr, instr_in[25], mode == 2'b10, (mode == 2'b00) && instr_in[20]};
      e.dest = instr_in[15:12];
      e.data = {rd_ref(r1), rd_ref(r2), instr_in[11:0], instr_in[23:0], r1, r2};
    end
    return e;
  endfunction

  task automatic check_outs(input int k, input exp_t e);
    string t = (k == 0) ? "nf" : "fw";
    check({t, " valid_out"}, valid_o[k], e.valid);
    check({t, " controls"}, {exec_o[k], mr_o[k], mw_o[k], wbe_o[k], imm_o[k], br_o[k], s_o[k]},
          e.ctrl);
    check({t, " pc_out"}, pc_o[k], e.pc);
    check({t, " dest"}, dest_o[k], e.dest);
    if (e.data_chk)
      check({t, " data"}, {rn_o[k], rm_o[k], sh_o[k], si_o[k], s1_o[k], s2_o[k]}, e.data);
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge
  task automatic step();
    exp_t e [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      e[k] = model(k == 1);
      check((k == 0) ? "nf stall" : "fw stall", stall_o[k], e[k].stall);
    end
    @(posedge clk);
    if (wb_en) model_rf[wb_addr] = wb_data;
    #1;
    for (int k = 0; k < 2; k++) check_outs(k, e[k]);
    @(negedge clk);
  endtask

  task automatic idle();
    pc_in = '0; instr_in = '0; valid_in = 0; wb_en = 0; wb_addr = '0; wb_data = '0;
    status_in = '0; ex_dest = '0; mem_dest = '0; ex_wb_en = 0; mem_wb_en = 0;
    ex_mem_read = 0; flush = 0;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    idle();
    wb_en = 1; wb_addr = a; wb_data = d;
    step();
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, " valid_out"}, valid_o[k], 1'b0);
      check({tag, " outputs"}, {pc_o[k], exec_o[k], mr_o[k], mw_o[k], wbe_o[k], imm_o[k], br_o[k],
            s_o[k], dest_o[k]}, '0);
      check({tag, " data"}, {rn_o[k], rm_o[k], sh_o[k], si_o[k], s1_o[k], s2_o[k]}, '0);
    end
  endtask

  localparam logic [31:0] AddR1R2R3 = 32'hE082_1003;
  localparam logic [31:0] AddR5R4R3 = 32'hE084_5003;
  localparam logic [31:0] AddEqR1   = 32'h0082_1003;

  initial begin
    // add/adc/sub/sbc/and/orr/eor/mov/mvn write back; cmp/tst only set flags
    for (int i = 0; i < 16; i++) begin exe_tab[i] = 4'h0; wr_tab[i] = 0; model_rf[i] = '0; end
    exe_tab[4'hD] = 4'h1; exe_tab[4'hF] = 4'h9; exe_tab[4'h4] = 4'h2; exe_tab[4'h5] = 4'h3;
    exe_tab[4'h2] = 4'h4; exe_tab[4'h6] = 4'h5; exe_tab[4'h0] = 4'h6; exe_tab[4'hC] = 4'h7;
    exe_tab[4'h1] = 4'h8; exe_tab[4'hA] = 4'h4; exe_tab[4'h8] = 4'h6;
    foreach (wr_tab[i]) wr_tab[i] = (i != 4'hA) && (i != 4'h8) && (exe_tab[i] != 4'h0);

    idle();
    #1 rst = 0;
    #1;
    reset_checks("reset");
    for (int k = 0; k < 2; k++) check("reset stall", stall_o[k], 1'b0);
    @(negedge clk);
    rst = 1;

    // ADD R1,R2,R3 with R2=5, R3=7
    write_reg(4'd2, 32'd5);
    write_reg(4'd3, 32'd7);
    idle(); instr_in = AddR1R2R3; valid_in = 1; pc_in = 32'h100;
    step();
    check("add val_rn", rn_o[0], 32'd5);
    check("add val_rm", rm_o[0], 32'd7);
    check("add wb_en_out", wbe_o[0], 1'b1);
    check("add dest", dest_o[0], 4'd1);

    // RAW on R2 in EXE; forwarding variant stalls only on a load
    ex_wb_en = 1; ex_dest = 4'd2;
    step();
    check("hazard nf stall", stall_o[0], 1'b1);
    check("hazard nf bubble", valid_o[0], 1'b0);
    check("hazard fw no stall", stall_o[1], 1'b0);
    ex_mem_read = 1;
    step();
    check("load-use fw stall", stall_o[1], 1'b1);
    ex_wb_en = 0; ex_mem_read = 0;
    step();
    check("hazard cleared issue", valid_o[0], 1'b1);

    // Same-cycle write-back bypass into Rn
    idle(); instr_in = AddR5R4R3; valid_in = 1; wb_en = 1; wb_addr = 4'd4; wb_data = 32'hDEAD;
    step();
    check("bypass val_rn", rn_o[0], 32'hDEAD);

    // Conditional execution
    idle(); instr_in = AddEqR1; valid_in = 1; pc_in = 32'h200; status_in = 4'b0000;
    step();
    check("eq fail valid", valid_o[0], 1'b0);
    check("eq fail wb_en_out", wbe_o[0], 1'b0);
    check("eq fail pc", pc_o[0], 32'h200);
    status_in = 4'b0100;
    step();
    check("eq pass valid", valid_o[0], 1'b1);

    // Flush overrides a hazard
    idle(); instr_in = AddR1R2R3; valid_in = 1; ex_wb_en = 1; ex_dest = 4'd2; flush = 1;
    step();
    check("flush stall", stall_o[0], 1'b0);
    check("flush bubble", valid_o[0], 1'b0);

    // Reset in the middle of a stall
    idle(); instr_in = AddR1R2R3; valid_in = 1; pc_in = 32'h300;
    step();
    ex_wb_en = 1; ex_dest = 4'd2;
    #1;
    check("pre-reset stall", stall_o[0], 1'b1);
    rst = 0;
    #1;
    reset_checks("mid-stall reset");
    foreach (model_rf[i]) model_rf[i] = '0;
    @(negedge clk);
    rst = 1; ex_wb_en = 0;
    step();
    check("post-reset issue", valid_o[0], 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      instr_in = $urandom;
      if ($urandom_range(0, 3) != 0) instr_in[31:28] = 4'hE;
      if ($urandom_range(0, 1) == 0) begin
        instr_in[19:16] = 4'($urandom_range(0, 3));
        instr_in[15:12] = 4'($urandom_range(0, 3));
        instr_in[3:0]   = 4'($urandom_range(0, 3));
      end
      pc_in       = $urandom;
      valid_in    = ($urandom_range(0, 7) != 0);
      wb_en       = $urandom_range(0, 1);
      wb_addr     = 4'($urandom_range(0, 15));
      wb_data     = $urandom;
      status_in   = 4'($urandom_range(0, 15));
      ex_dest     = 4'($urandom_range(0, 3));
      mem_dest    = 4'($urandom_range(0, 3));
      ex_wb_en    = $urandom_range(0, 1);
      mem_wb_en   = $urandom_range(0, 1);
      ex_mem_read = $urandom_range(0, 1);
      flush       = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
